tile_grid_renderer: RTL and testbench
=====================================

Name: tile_grid_renderer

Overview:
- Parametrised raster engine that paints a COLS x ROWS grid of solid tiles, each TILE_W x TILE_H pixels, into the VGA pixel-write interface.
- Per-tile colour comes from a grid occupancy vector: lit tiles use FG_COLOR, unlit tiles use BG_COLOR.
- A row mask selects which tile rows are redrawn in one pass. This replaces separate spawn/shift drawers with one sequencer, driven by the game controller through a start/busy/done handshake.

Parameters:
- COLS, 4, tile columns
- ROWS, 4, tile rows
- TILE_W, 160, tile width in pixels
- TILE_H, 120, tile height in pixels
- X_W, 10, VGA_X width; must satisfy COLS*TILE_W <= 2^X_W
- Y_W, 9, VGA_Y width; must satisfy ROWS*TILE_H <= 2^Y_W
- COLOR_W, 9, colour width
- FG_COLOR, 9'h1FF, lit-tile colour
- BG_COLOR, 9'h05A, unlit-tile colour

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a redraw pass; sampled only in IDLE
- grid  in  COLS*ROWS  bit r*COLS+c = 1 means tile (row r, col c) is lit
- row_mask  in  ROWS  bit r = 1 means row r is drawn this pass
- VGA_X  out  X_W  pixel x
- VGA_Y  out  Y_W  pixel y
- VGA_COLOR  out  COLOR_W  pixel colour
- plot  out  1  pixel write enable; VGA_X/VGA_Y/VGA_COLOR are valid only when plot=1
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse when a pass ends
- cur_row  out  clog2(ROWS) (min 1)  row currently being drawn; debug

Behaviour:
- Reset (async, any state): state=IDLE; VGA_X=0, VGA_Y=0, VGA_COLOR=BG_COLOR, plot=0, busy=0, done=0, cur_row=0. Internal snapshot registers are cleared.
- States: IDLE, DRAW, FIN.
- IDLE:
  - plot=0, busy=0.
  - start=1 with row_mask!=0: snapshot grid and row_mask; cur_row = lowest set bit of row_mask; go to DRAW; busy=1 from the next cycle.
  - start=1 with row_mask==0: go to FIN; no plot cycles.
- DRAW:
  - Exactly one pixel per cycle, plot=1.
  - Order within a row: tile col 0..COLS-1; inside each tile, y outer 0..TILE_H-1 and x inner 0..TILE_W-1.
  - VGA_X = col*TILE_W + px; VGA_Y = cur_row*TILE_H + py.
  - VGA_COLOR = FG_COLOR if snapshot bit (cur_row*COLS+col) is set, else BG_COLOR.
  - Latency: start sampled at edge k gives the first pixel (the top-left of the first selected row) registered at edge k+1.
  - After the last pixel of a row, advance directly to the next higher set bit of the snapshot mask. Row skips take zero cycles and produce no plot gap.
  - After the last pixel of the highest selected row, go to FIN.
- FIN: plot=0, busy=0, done=1 for exactly one cycle, then IDLE. A start in the FIN cycle is ignored.
- Pass length is exactly popcount(row_mask)*COLS*TILE_W*TILE_H plot cycles, contiguous.
- Input changes on grid and row_mask during busy have no effect on the pass in progress (snapshot).
- start while busy=1 is ignored and is not queued.
- Coordinate arithmetic is unsigned at X_W/Y_W width. Counters wrap exactly at TILE_W-1, TILE_H-1, COLS-1. No coordinate ever reaches COLS*TILE_W or ROWS*TILE_H.
- Reset asserted mid-DRAW aborts the pass immediately: plot=0, no done pulse. After release, the block sits in IDLE.
- Outputs hold their last values while plot=0, except VGA_COLOR, which resets to BG_COLOR only on reset.

Test Plan:
- Bench parameters: COLS=2, ROWS=2, TILE_W=4, TILE_H=2.
- Full pass: grid=4'b1001, row_mask=2'b11, start pulse.
  - Expect 32 contiguous plot cycles.
  - First pixel (0,0) FG; pixel (4,0) BG; pixel (0,2) BG; last pixel (7,3) FG.
  - done pulses once on the cycle after the last pixel.
- Row skip: row_mask=2'b10, grid=4'b0100.
  - Expect 16 plot cycles with all VGA_Y in {2,3}.
  - Col 0 tiles FG, col 1 tiles BG.
  - First plot at edge k+1 after start.
- Empty mask: row_mask=0, start.
  - Expect zero plot cycles, busy never high, done pulse on the cycle after start.
- Snapshot and start-ignore:
  - Toggle grid every cycle and pulse start repeatedly while busy.
  - Colours match the grid value at the start edge; exactly one done per accepted start.
- Reset mid-pass: assert reset at plot cycle 10.
  - plot=0 and VGA_COLOR=BG_COLOR immediately (asynchronously); no done pulse.
  - A new start after release produces a full 32-cycle pass.
- Raster order check (scoreboard): for the full pass, every (x,y) in 0..7 x 0..3 is plotted exactly once, in the specified tile/row-major order.

Source files
------------

// File: rtl/tile_grid_renderer_if.sv
// Redraw request/handshake from the game controller plus the VGA pixel-write port of the renderer.
// Names of the individual signals match the board-level VGA adapter and controller wiring.
interface tile_grid_renderer_if #(
  parameter int COLS    = 4,
  parameter int ROWS    = 4,
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int COLOR_W = 9
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                 start;
  logic [COLS*ROWS-1:0] grid;
  logic [ROWS-1:0]      row_mask;
  logic [X_W-1:0]       VGA_X;
  logic [Y_W-1:0]       VGA_Y;
  logic [COLOR_W-1:0]   VGA_COLOR;
  logic                 plot;
  logic                 busy;
  logic                 done;
  logic [ROW_W-1:0]     cur_row;

  modport master (
    output start, grid, row_mask,
    input  VGA_X, VGA_Y, VGA_COLOR, plot, busy, done, cur_row
  );

  modport slave (
    input  start, grid, row_mask,
    output VGA_X, VGA_Y, VGA_COLOR, plot, busy, done, cur_row
  );
endinterface

// File: rtl/tile_grid_renderer.sv
// Paints selected rows of a COLS x ROWS solid-tile grid one pixel per cycle; first pixel one cycle after start.
// No backpressure: the VGA side must accept a pixel every plot cycle; start is ignored while busy or in FIN.
module tile_grid_renderer #(
  parameter int                 COLS     = 4,
  parameter int                 ROWS     = 4,
  parameter int                 TILE_W   = 160,
  parameter int                 TILE_H   = 120,
  parameter int                 X_W      = 10,
  parameter int                 Y_W      = 9,
  parameter int                 COLOR_W  = 9,
  parameter logic [COLOR_W-1:0] FG_COLOR = 9'h1FF,
  parameter logic [COLOR_W-1:0] BG_COLOR = 9'h05A
) (
  input logic                 CLOCK_50,
  input logic                 reset,
  tile_grid_renderer_if.slave bus
);
  localparam int ROW_W = (ROWS > 1)   ? $clog2(ROWS)   : 1;
  localparam int COL_W = (COLS > 1)   ? $clog2(COLS)   : 1;
  localparam int PX_W  = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int PY_W  = (TILE_H > 1) ? $clog2(TILE_H) : 1;

  localparam logic [X_W-1:0]   TW_X     = X_W'(TILE_W);
  localparam logic [Y_W-1:0]   TH_Y     = Y_W'(TILE_H);
  localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(TILE_W - 1);
  localparam logic [PY_W-1:0]  PY_LAST  = PY_W'(TILE_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

  state_t               state_q, state_d;
  logic [COLS*ROWS-1:0] snap_grid_q, snap_grid_d;
  logic [ROWS-1:0]      snap_mask_q, snap_mask_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [PX_W-1:0]      px_q, px_d;
  logic [PY_W-1:0]      py_q, py_d;
  logic                 drain_q, drain_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic                 plot_q, plot_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [ROW_W-1:0]     start_row;
  logic [ROW_W-1:0]     next_row;
  logic                 has_next;
  logic                 tile_lit;

  always_comb begin
    start_row = '0;
    for (int r = ROWS - 1; r >= 0; r--)
      if (bus.row_mask[r]) start_row = ROW_W'(r);
  end

  // Next selected row strictly above the current one; lets row skips cost zero cycles.
  always_comb begin
    next_row = '0;
    has_next = 1'b0;
    for (int r = ROWS - 1; r >= 0; r--)
      if (snap_mask_q[r] && (r > int'(row_q))) begin
        next_row = ROW_W'(r);
        has_next = 1'b1;
      end
  end

  always_comb begin
    tile_lit = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (r == int'(row_q) && c == int'(col_q)) tile_lit = snap_grid_q[r*COLS + c];
  end

  always_comb begin
    state_d     = state_q;
    snap_grid_d = snap_grid_q;
    snap_mask_d = snap_mask_q;
    row_d       = row_q;
    col_d       = col_q;
    px_d        = px_q;
    py_d        = py_q;
    drain_d     = drain_q;
    x_d         = x_q;
    y_d         = y_q;
    color_d     = color_q;
    plot_d      = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          if (|bus.row_mask) begin
            snap_grid_d = bus.grid;
            snap_mask_d = bus.row_mask;
            row_d       = start_row;
            col_d       = '0;
            px_d        = '0;
            py_d        = '0;
            drain_d     = 1'b0;
            busy_d      = 1'b1;
            state_d     = DRAW;
          end else begin
            done_d  = 1'b1;
            state_d = FIN;
          end
        end
      end

      DRAW: begin
        // Counters lead the output registers by one cycle; drain marks the last pixel already emitted.
        if (drain_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          plot_d  = 1'b1;
          x_d     = X_W'(col_q) * TW_X + X_W'(px_q);
          y_d     = Y_W'(row_q) * TH_Y + Y_W'(py_q);
          color_d = tile_lit ? FG_COLOR : BG_COLOR;
          if (px_q == PX_LAST) begin
            px_d = '0;
            if (py_q == PY_LAST) begin
              py_d = '0;
              if (col_q == COL_LAST) begin
                col_d = '0;
                if (has_next) row_d = next_row;
                else          drain_d = 1'b1;
              end else begin
                col_d = col_q + 1'b1;
              end
            end else begin
              py_d = py_q + 1'b1;
            end
          end else begin
            px_d = px_q + 1'b1;
          end
        end
      end

      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      snap_grid_q <= '0;
      snap_mask_q <= '0;
      row_q       <= '0;
      col_q       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      drain_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      color_q     <= BG_COLOR;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_grid_q <= snap_grid_d;
      snap_mask_q <= snap_mask_d;
      row_q       <= row_d;
      col_q       <= col_d;
      px_q        <= px_d;
      py_q        <= py_d;
      drain_q     <= drain_d;
      x_q         <= x_d;
      y_q         <= y_d;
      color_q     <= color_d;
      plot_q      <= plot_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.VGA_X     = x_q;
  assign bus.VGA_Y     = y_q;
  assign bus.VGA_COLOR = color_q;
  assign bus.plot      = plot_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cur_row   = row_q;
endmodule

// File: tb/tb_tile_grid_renderer.sv
// Bench for tile_grid_renderer on a 2x2 grid of 4x2 tiles, with a raster reference model and scoreboard.
module tb_tile_grid_renderer;
  localparam int COLS = 2, ROWS = 2, TILE_W = 4, TILE_H = 2;
  localparam logic [8:0] FG = 9'h1FF;
  localparam logic [8:0] BG = 9'h05A;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [8:0] c;
  } pix_t;

  logic CLOCK_50 = 1'b0;
  logic reset;
  always #5 CLOCK_50 = ~CLOCK_50;

  tile_grid_renderer_if #(.COLS(COLS), .ROWS(ROWS), .X_W(10), .Y_W(9), .COLOR_W(9)) bus ();

  tile_grid_renderer #(
    .COLS(COLS), .ROWS(ROWS), .TILE_W(TILE_W), .TILE_H(TILE_H),
    .X_W(10), .Y_W(9), .COLOR_W(9), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  pix_t got_q[$];
  pix_t exp_q[$];
  int   first_plot, last_plot, gap_cnt, done_cnt, done_cyc, busy_cnt;
  logic first_cur_row;

  // Reference raster: selected rows bottom-up, tiles left to right, y outer, x inner.
  function automatic void build_expected(input logic [3:0] g, input logic [1:0] m);
    exp_q.delete();
    for (int r = 0; r < ROWS; r++)
      if (m[r])
        for (int c = 0; c < COLS; c++)
          for (int py = 0; py < TILE_H; py++)
            for (int px = 0; px < TILE_W; px++)
              exp_q.push_back('{x: 10'(c*TILE_W + px), y: 9'(r*TILE_H + py),
                                c: g[r*COLS + c] ? FG : BG});
  endfunction

  function automatic int pixel_mismatches();
    int bad = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) begin
        if (bad < 4)
          $display("FAIL pixel[%0d]: got x=%0d y=%0d c=%h, want x=%0d y=%0d c=%h", i,
                   got_q[i].x, got_q[i].y, got_q[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
        bad++;
      end
    return bad;
  endfunction

  function automatic logic [8:0] color_at(input int x, input int y);
    logic [8:0] c = 'x;
    foreach (got_q[i])
      if (int'(got_q[i].x) == x && int'(got_q[i].y) == y) c = got_q[i].c;
    return c;
  endfunction

  // Called at a negedge; cycle i counts negedges after the start edge.
  task automatic start_and_capture(input logic [3:0] g, input logic [1:0] m, input int ncyc,
                                   input bit toggle, input bit spam);
    got_q.delete();
    first_plot = -1; last_plot = -1; gap_cnt = 0;
    done_cnt = 0; done_cyc = -1; busy_cnt = 0;
    bus.grid = g; bus.row_mask = m; bus.start = 1'b1;
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    first_cur_row = bus.cur_row;
    for (int i = 1; i <= ncyc; i++) begin
      if (bus.plot) begin
        got_q.push_back('{x: bus.VGA_X, y: bus.VGA_Y, c: bus.VGA_COLOR});
        if (first_plot < 0) first_plot = i;
        if (last_plot >= 0 && last_plot != i - 1) gap_cnt++;
        last_plot = i;
      end
      if (bus.done) begin done_cnt++; done_cyc = i; end
      if (bus.busy) busy_cnt++;
      if (toggle) begin
        bus.grid     = 4'($urandom);
        bus.row_mask = 2'($urandom);
      end
      bus.start = (spam && bus.busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge CLOCK_50);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.grid = '0; bus.row_mask = '0;
    repeat (2) @(negedge CLOCK_50);
    n_checks++; if (bus.plot !== 1'b0) begin n_fail++; $display("FAIL reset_plot: got %b want 0", bus.plot); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.VGA_X !== 10'd0 || bus.VGA_Y !== 9'd0) begin n_fail++;
      $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", bus.VGA_X, bus.VGA_Y); end
    n_checks++; if (bus.VGA_COLOR !== BG) begin n_fail++; $display("FAIL reset_color: got %h want %h", bus.VGA_COLOR, BG); end
    n_checks++; if (bus.cur_row !== 1'b0) begin n_fail++; $display("FAIL reset_cur_row: got %0d want 0", bus.cur_row); end
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    n_checks++; if (bus.busy !== 1'b0 || bus.plot !== 1'b0) begin n_fail++;
      $display("FAIL idle_after_reset: busy=%b plot=%b want 0 0", bus.busy, bus.plot); end
  endtask

  task automatic test_full_pass();
    int hits[8][4];
    int bad_cells;
    build_expected(4'b1001, 2'b11);
    start_and_capture(4'b1001, 2'b11, 40, 1'b0, 1'b0);
    n_checks++; if (got_q.size() != 32) begin n_fail++; $display("FAIL full_count: got %0d want 32", got_q.size()); end
    n_checks++; if (first_plot != 2) begin n_fail++; $display("FAIL full_latency: got cycle %0d want 2", first_plot); end
    n_checks++; if (gap_cnt != 0) begin n_fail++; $display("FAIL full_contiguous: got %0d gaps want 0", gap_cnt); end
    n_checks++; if (done_cnt != 1 || done_cyc != 34) begin n_fail++;
      $display("FAIL full_done: got %0d pulses at cycle %0d want 1 at 34", done_cnt, done_cyc); end
    n_checks++; if (busy_cnt != 33) begin n_fail++; $display("FAIL full_busy: got %0d cycles want 33", busy_cnt); end
    n_checks++; if (color_at(0, 0) !== FG) begin n_fail++; $display("FAIL px_0_0: got %h want %h", color_at(0, 0), FG); end
    n_checks++; if (color_at(4, 0) !== BG) begin n_fail++; $display("FAIL px_4_0: got %h want %h", color_at(4, 0), BG); end
    n_checks++; if (color_at(0, 2) !== BG) begin n_fail++; $display("FAIL px_0_2: got %h want %h", color_at(0, 2), BG); end
    n_checks++; if (color_at(7, 3) !== FG) begin n_fail++; $display("FAIL px_7_3: got %h want %h", color_at(7, 3), FG); end
    n_checks++; if (pixel_mismatches() != 0) begin n_fail++; $display("FAIL full_order: got mismatching raster want model order"); end
    foreach (hits[i, j]) hits[i][j] = 0;
    bad_cells = 0;
    foreach (got_q[i])
      if (got_q[i].x < 8 && got_q[i].y < 4) hits[got_q[i].x][got_q[i].y]++;
      else bad_cells++;
    foreach (hits[i, j]) if (hits[i][j] != 1) bad_cells++;
    n_checks++; if (bad_cells != 0) begin n_fail++; $display("FAIL full_coverage: got %0d bad cells want 0", bad_cells); end
  endtask

  task automatic test_row_skip();
    int bad_y = 0, bad_c = 0;
    start_and_capture(4'b0100, 2'b10, 30, 1'b0, 1'b0);
    n_checks++; if (got_q.size() != 16) begin n_fail++; $display("FAIL skip_count: got %0d want 16", got_q.size()); end
    n_checks++; if (first_plot != 2) begin n_fail++; $display("FAIL skip_latency: got cycle %0d want 2", first_plot); end
    n_checks++; if (first_cur_row !== 1'b1) begin n_fail++; $display("FAIL skip_cur_row: got %0d want 1", first_cur_row); end
    foreach (got_q[i]) begin
      if (got_q[i].y != 2 && got_q[i].y != 3) bad_y++;
      if (got_q[i].c !== ((got_q[i].x < 4) ? FG : BG)) bad_c++;
    end
    n_checks++; if (bad_y != 0) begin n_fail++; $display("FAIL skip_rows: got %0d pixels outside y 2..3 want 0", bad_y); end
    n_checks++; if (bad_c != 0) begin n_fail++; $display("FAIL skip_colors: got %0d wrong colours want 0", bad_c); end
    n_checks++; if (done_cnt != 1 || done_cyc != 18) begin n_fail++;
      $display("FAIL skip_done: got %0d pulses at cycle %0d want 1 at 18", done_cnt, done_cyc); end
  endtask

  task automatic test_empty_mask();
    start_and_capture(4'b1111, 2'b00, 6, 1'b0, 1'b0);
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL empty_plots: got %0d want 0", got_q.size()); end
    n_checks++; if (busy_cnt != 0) begin n_fail++; $display("FAIL empty_busy: got %0d busy cycles want 0", busy_cnt); end
    n_checks++; if (done_cnt != 1 || done_cyc != 1) begin n_fail++;
      $display("FAIL empty_done: got %0d pulses at cycle %0d want 1 at 1", done_cnt, done_cyc); end
  endtask

  task automatic test_snapshot();
    for (int k = 0; k < 8; k++) begin
      logic [3:0] g = 4'($urandom);
      logic [1:0] m = 2'($urandom_range(0, 3));
      build_expected(g, m);
      start_and_capture(g, m, 40, 1'b1, 1'b1);
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++;
        $display("FAIL snap_count[%0d]: got %0d want %0d", k, got_q.size(), exp_q.size()); end
      n_checks++; if (pixel_mismatches() != 0) begin n_fail++; $display("FAIL snap_pixels[%0d]: got mismatches want 0", k); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL snap_done[%0d]: got %0d want 1", k, done_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    int nplot = 0, stray = 0;
    bus.grid = 4'b1001; bus.row_mask = 2'b11; bus.start = 1'b1;
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    for (int i = 0; i < 40 && nplot < 10; i++) begin
      @(negedge CLOCK_50);
      if (bus.plot) nplot++;
    end
    n_checks++; if (nplot != 10) begin n_fail++; $display("FAIL rst_mid_reach: got %0d plots want 10", nplot); end
    reset = 1'b1;
    #1;
    n_checks++; if (bus.plot !== 1'b0) begin n_fail++; $display("FAIL rst_mid_plot: got %b want 0", bus.plot); end
    n_checks++; if (bus.VGA_COLOR !== BG) begin n_fail++; $display("FAIL rst_mid_color: got %h want %h", bus.VGA_COLOR, BG); end
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++;
      $display("FAIL rst_mid_flags: busy=%b done=%b want 0 0", bus.busy, bus.done); end
    @(negedge CLOCK_50);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK_50);
      if (bus.done || bus.plot || bus.busy) stray++;
    end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL rst_mid_idle: got %0d active cycles want 0", stray); end
    build_expected(4'b1001, 2'b11);
    start_and_capture(4'b1001, 2'b11, 40, 1'b0, 1'b0);
    n_checks++; if (got_q.size() != 32) begin n_fail++; $display("FAIL rst_mid_rerun: got %0d plots want 32", got_q.size()); end
    n_checks++; if (pixel_mismatches() != 0 || done_cnt != 1) begin n_fail++;
      $display("FAIL rst_mid_rerun_pass: got done=%0d or bad pixels want clean pass", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_row_skip();
    test_empty_mask();
    test_snapshot();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
